// File: rtl/video_fetch.sv
// Port-B video RAM reader: once per frame, fetches the five video words into staging
// registers and commits them to the slot outputs together, so a frame is never half-updated.
module video_fetch #(
   parameter int READ_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic [31:0] DataVideo,
   output logic [31:0] addr_B,
   output logic [31:0] slot0,
   output logic [31:0] slot1,
   output logic [31:0] slot2,
   output logic [31:0] slot3,
   output logic [31:0] slot4,
   output logic        busy,
   output logic        frame_valid,
   output logic        overrun,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          i_q, i_d;
   logic                pend_q, pend_d;
   logic [READ_LAT-1:0] pv_q;
   logic [2:0]          pi_q [READ_LAT];
   logic [31:0]         stg_q [5];
   logic [31:0]         slot_q [5];
   logic                busy_q, fv_q, ovr_q;
   logic                cap, commit, restart;

   // The oldest pipeline entry lines up with the DataVideo word for its address.
   assign cap     = pv_q[READ_LAT-1];
   assign commit  = cap && (pi_q[READ_LAT-1] == 3'd4);
   assign restart = commit && (pend_q || frame_start);

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      pend_d  = pend_q;
      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d = S_FETCH;
               i_d     = 3'd0;
            end
         end
         S_FETCH: begin
            if (i_q == 3'd4) state_d = S_DRAIN;
            else             i_d     = i_q + 3'd1;
         end
         S_DRAIN: begin
            if (commit) begin
               state_d = restart ? S_FETCH : S_IDLE;
               i_d     = 3'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
            i_d     = 3'd0;
         end
      endcase
      // A restart at commit consumes the pending request, whether old or arriving now.
      if (commit)                               pend_d = 1'b0;
      else if (frame_start && state_q != S_IDLE) pend_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         i_q     <= 3'd0;
         pend_q  <= 1'b0;
         pv_q    <= '0;
         for (int j = 0; j < READ_LAT; j++) pi_q[j] <= 3'd0;
         for (int k = 0; k < 5; k++) begin
            stg_q[k]  <= 32'd0;
            slot_q[k] <= 32'd0;
         end
         busy_q  <= 1'b0;
         fv_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         pend_q  <= pend_d;
         pv_q[0] <= (state_q == S_FETCH);
         pi_q[0] <= i_q;
         for (int j = 1; j < READ_LAT; j++) begin
            pv_q[j] <= pv_q[j-1];
            pi_q[j] <= pi_q[j-1];
         end
         if (cap) stg_q[pi_q[READ_LAT-1]] <= DataVideo;
         // Word 4 bypasses staging so all five slots load on the same edge.
         if (commit) begin
            for (int k = 0; k < 4; k++) slot_q[k] <= stg_q[k];
            slot_q[4] <= DataVideo;
         end
         busy_q  <= (state_d != S_IDLE);
         fv_q    <= commit;
         ovr_q   <= frame_start && (state_q != S_IDLE) && pend_q;
      end
   end

   always_comb begin
      case (i_q)
         3'd0:    addr_B = 32'h0000_6000;
         3'd1:    addr_B = 32'h0000_7000;
         3'd2:    addr_B = 32'h0000_8000;
         3'd3:    addr_B = 32'h0000_9000;
         default: addr_B = 32'h0001_0000;
      endcase
   end

   assign slot0       = slot_q[0];
   assign slot1       = slot_q[1];
   assign slot2       = slot_q[2];
   assign slot3       = slot_q[3];
   assign slot4       = slot_q[4];
   assign busy        = busy_q;
   assign frame_valid = fv_q;
   assign overrun     = ovr_q;
   assign dbg_state   = state_q;

endmodule
